// File: rtl/leve1_rd_arb.sv
// Two-requester read-port arbiter: shares one memory AR/R channel between
// instruction fetch (I) and data load (D), one transaction at a time, round-robin on ties.
module leve1_rd_arb #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          CLK,
    input  logic          RSTn,
    // fetch side
    input  logic          I_ARVALID,
    output logic          I_ARREADY,
    input  logic [AW-1:0] I_ARADDR,
    output logic          I_RVALID,
    input  logic          I_RREADY,
    output logic [DW-1:0] I_RDATA,
    output logic [1:0]    I_RRESP,
    // load side
    input  logic          D_ARVALID,
    output logic          D_ARREADY,
    input  logic [AW-1:0] D_ARADDR,
    output logic          D_RVALID,
    input  logic          D_RREADY,
    output logic [DW-1:0] D_RDATA,
    output logic [1:0]    D_RRESP,
    // memory side
    output logic          M_ARVALID,
    input  logic          M_ARREADY,
    output logic [AW-1:0] M_ARADDR,
    input  logic          M_RVALID,
    output logic          M_RREADY,
    input  logic [DW-1:0] M_RDATA,
    input  logic [1:0]    M_RRESP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;     // 0 = I, 1 = D
    logic          last_q, last_d;   // side granted most recently
    logic [AW-1:0] addr_q, addr_d;
    logic          pick;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    // On a tie the side that did not win last time is picked.
    assign pick = (I_ARVALID && D_ARVALID) ? ~last_q : D_ARVALID;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        I_ARREADY = 1'b0;
        D_ARREADY = 1'b0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        I_RVALID  = 1'b0;
        D_RVALID  = 1'b0;

        unique case (state_q)
            IDLE: begin
                I_ARREADY = I_ARVALID && !pick;
                D_ARREADY = D_ARVALID && pick;
                if (I_ARVALID || D_ARVALID) begin
                    addr_d  = pick ? D_ARADDR : I_ARADDR;
                    gnt_d   = pick;
                    last_d  = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                I_RVALID = M_RVALID && !gnt_q;
                D_RVALID = M_RVALID && gnt_q;
                M_RREADY = gnt_q ? D_RREADY : I_RREADY;
                if (M_RVALID && M_RREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign M_ARADDR = addr_q;
    assign I_RDATA  = M_RDATA;
    assign I_RRESP  = M_RRESP;
    assign D_RDATA  = M_RDATA;
    assign D_RRESP  = M_RRESP;

endmodule

// File: tb/tb_leve1_rd_arb.sv
// Directed bench for leve1_rd_arb: per-cycle vector table plus hand-written
// backpressure, back-to-back and asynchronous-reset sequences.
module tb_leve1_rd_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          I_ARVALID, I_ARREADY, I_RVALID, I_RREADY;
    logic [AW-1:0] I_ARADDR;
    logic [DW-1:0] I_RDATA;
    logic [1:0]    I_RRESP;
    logic          D_ARVALID, D_ARREADY, D_RVALID, D_RREADY;
    logic [AW-1:0] D_ARADDR;
    logic [DW-1:0] D_RDATA;
    logic [1:0]    D_RRESP;
    logic          M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [AW-1:0] M_ARADDR;
    logic [DW-1:0] M_RDATA;
    logic [1:0]    M_RRESP;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    leve1_rd_arb #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .I_ARVALID(I_ARVALID), .I_ARREADY(I_ARREADY), .I_ARADDR(I_ARADDR),
        .I_RVALID(I_RVALID), .I_RREADY(I_RREADY), .I_RDATA(I_RDATA), .I_RRESP(I_RRESP),
        .D_ARVALID(D_ARVALID), .D_ARREADY(D_ARREADY), .D_ARADDR(D_ARADDR),
        .D_RVALID(D_RVALID), .D_RREADY(D_RREADY), .D_RDATA(D_RDATA), .D_RRESP(D_RRESP),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP)
    );

    typedef struct {
        logic        iv;  logic [31:0] ia;
        logic        dv;  logic [31:0] da;
        logic        irr; logic        drr;
        logic        marr; logic       mrv;
        logic [31:0] mrd; logic [1:0]  mrs;
        logic        e_iarr, e_darr, e_mav;
        logic [31:0] e_maddr;
        logic        e_mrr, e_irv, e_drv;
    } vec_t;

    function automatic vec_t v(
        input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
        input logic irr, input logic drr, input logic marr, input logic mrv,
        input logic [31:0] mrd, input logic [1:0] mrs,
        input logic e_iarr, input logic e_darr, input logic e_mav, input logic [31:0] e_maddr,
        input logic e_mrr, input logic e_irv, input logic e_drv);
        vec_t r;
        r.iv = iv; r.ia = ia; r.dv = dv; r.da = da; r.irr = irr; r.drr = drr;
        r.marr = marr; r.mrv = mrv; r.mrd = mrd; r.mrs = mrs;
        r.e_iarr = e_iarr; r.e_darr = e_darr; r.e_mav = e_mav; r.e_maddr = e_maddr;
        r.e_mrr = e_mrr; r.e_irv = e_irv; r.e_drv = e_drv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        I_ARVALID = 1'b0; I_ARADDR = '0; I_RREADY = 1'b0;
        D_ARVALID = 1'b0; D_ARADDR = '0; D_RREADY = 1'b0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
    endtask

    task automatic chk_ctl(input string tag, input logic iarr, input logic darr, input logic mav,
                           input logic mrr, input logic irv, input logic drv);
        chk({tag, ".I_ARREADY"}, 32'(I_ARREADY), 32'(iarr));
        chk({tag, ".D_ARREADY"}, 32'(D_ARREADY), 32'(darr));
        chk({tag, ".M_ARVALID"}, 32'(M_ARVALID), 32'(mav));
        chk({tag, ".M_RREADY"},  32'(M_RREADY),  32'(mrr));
        chk({tag, ".I_RVALID"},  32'(I_RVALID),  32'(irv));
        chk({tag, ".D_RVALID"},  32'(D_RVALID),  32'(drv));
    endtask

    vec_t tbl[16];

    initial begin
        // after reset last=1: tie -> I, then D, then I; stalls on R; withdraw; single fetch
        //          iv ia         dv da         irr drr marr mrv mrd           mrs    iarr darr mav maddr      mrr irv drv
        tbl[0]  = v(1, 32'h200, 1, 32'h300, 0, 0, 0, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,   0, 0, 0);
        tbl[1]  = v(0, 32'h0,   1, 32'h300, 0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 1, 32'h200, 0, 0, 0);
        tbl[2]  = v(0, 32'h0,   1, 32'h300, 0, 0, 1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h200, 0, 0, 0);
        tbl[3]  = v(0, 32'h0,   1, 32'h300, 1, 0, 0, 1, 32'h11111111, 2'b00, 0, 0, 0, 32'h0,   1, 1, 0);
        tbl[4]  = v(1, 32'h204, 1, 32'h300, 0, 0, 0, 0, 32'h0,        2'b00, 0, 1, 0, 32'h0,   0, 0, 0);
        tbl[5]  = v(1, 32'h204, 0, 32'h0,   0, 0, 1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h300, 0, 0, 0);
        tbl[6]  = v(1, 32'h204, 0, 32'h0,   0, 1, 0, 1, 32'h22222222, 2'b10, 0, 0, 0, 32'h0,   1, 0, 1);
        tbl[7]  = v(1, 32'h204, 1, 32'h304, 0, 0, 0, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,   0, 0, 0);
        tbl[8]  = v(0, 32'h0,   1, 32'h304, 0, 0, 1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h204, 0, 0, 0);
        tbl[9]  = v(0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   1, 0, 0);
        tbl[10] = v(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 2'b01, 0, 0, 0, 32'h0,   1, 1, 0);
        tbl[11] = v(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   0, 0, 0);
        tbl[12] = v(1, 32'h100, 0, 32'h0,   0, 0, 0, 0, 32'h0,        2'b00, 1, 0, 0, 32'h0,   0, 0, 0);
        tbl[13] = v(0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,        2'b00, 0, 0, 1, 32'h100, 0, 0, 0);
        tbl[14] = v(0, 32'h0,   0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'h0,   1, 1, 0);
        tbl[15] = v(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   0, 0, 0);

        RSTn = 1'b0;
        zero_inputs();
        @(negedge CLK);
        chk_ctl("reset", 0, 0, 0, 0, 0, 0);
        #2 RSTn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            string tag;
            @(negedge CLK);
            I_ARVALID = tbl[i].iv;  I_ARADDR = tbl[i].ia;
            D_ARVALID = tbl[i].dv;  D_ARADDR = tbl[i].da;
            I_RREADY  = tbl[i].irr; D_RREADY = tbl[i].drr;
            M_ARREADY = tbl[i].marr; M_RVALID = tbl[i].mrv;
            M_RDATA   = tbl[i].mrd;  M_RRESP  = tbl[i].mrs;
            #1;
            tag = $sformatf("vec%0d", i);
            chk_ctl(tag, tbl[i].e_iarr, tbl[i].e_darr, tbl[i].e_mav,
                    tbl[i].e_mrr, tbl[i].e_irv, tbl[i].e_drv);
            if (tbl[i].e_mav)
                chk({tag, ".M_ARADDR"}, M_ARADDR, tbl[i].e_maddr);
            if (tbl[i].e_irv) begin
                chk({tag, ".I_RDATA"}, I_RDATA, tbl[i].mrd);
                chk({tag, ".I_RRESP"}, 32'(I_RRESP), 32'(tbl[i].mrs));
            end
            if (tbl[i].e_drv) begin
                chk({tag, ".D_RDATA"}, D_RDATA, tbl[i].mrd);
                chk({tag, ".D_RRESP"}, 32'(D_RRESP), 32'(tbl[i].mrs));
            end
        end

        // Backpressure on AR for 4 cycles, then R stalled by D_RREADY=0 for 3 cycles.
        @(negedge CLK);
        zero_inputs();
        D_ARVALID = 1'b1; D_ARADDR = 32'h400;
        #1 chk_ctl("bp.req", 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            zero_inputs();
            #1;
            chk_ctl($sformatf("bp.ar%0d", k), 0, 0, 1, 0, 0, 0);
            chk($sformatf("bp.ar%0d.M_ARADDR", k), M_ARADDR, 32'h400);
        end
        @(negedge CLK);
        M_ARREADY = 1'b1;
        #1 chk("bp.arhs.M_ARADDR", M_ARADDR, 32'h400);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            zero_inputs();
            M_RVALID = 1'b1; M_RDATA = 32'hBEEF0400; M_RRESP = 2'b01;
            #1;
            chk_ctl($sformatf("bp.r%0d", k), 0, 0, 0, 0, 0, 1);
            chk($sformatf("bp.r%0d.D_RDATA", k), D_RDATA, 32'hBEEF0400);
        end
        @(negedge CLK);
        D_RREADY = 1'b1;
        #1 chk_ctl("bp.rhs", 0, 0, 0, 1, 0, 1);
        @(negedge CLK);
        zero_inputs();
        #1 chk_ctl("bp.idle", 0, 0, 0, 0, 0, 0);

        // Back-to-back fetch with zero-wait memory: one accept every 3 cycles, in order.
        for (int k = 0; k < 9; k++) begin
            logic [31:0] a;
            @(negedge CLK);
            a = 32'h1000 + 32'(4 * (k / 3));
            I_ARVALID = 1'b1; I_ARADDR = a; I_RREADY = 1'b1;
            M_ARREADY = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'(k);
            #1;
            chk($sformatf("b2b%0d.I_ARREADY", k), 32'(I_ARREADY), 32'((k % 3) == 0));
            if ((k % 3) == 1)
                chk($sformatf("b2b%0d.M_ARADDR", k), M_ARADDR, a);
            if ((k % 3) == 2)
                chk($sformatf("b2b%0d.I_RVALID", k), 32'(I_RVALID), 32'd1);
        end

        // Asynchronous reset while stalled in DATA.
        @(negedge CLK);
        zero_inputs();
        I_ARVALID = 1'b1; I_ARADDR = 32'h500;
        #1 chk_ctl("ar.req", 1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        zero_inputs();
        M_ARREADY = 1'b1;
        #1 chk("ar.addr.M_ARADDR", M_ARADDR, 32'h500);
        @(negedge CLK);
        zero_inputs();
        M_RVALID = 1'b1; M_RDATA = 32'hCAFE0001;
        #1 chk_ctl("ar.data", 0, 0, 0, 0, 1, 0);
        #1;
        RSTn = 1'b0;
        I_ARVALID = 1'b1; I_ARADDR = 32'h600;
        D_ARVALID = 1'b1; D_ARADDR = 32'h700;
        #1 chk_ctl("ar.inreset", 1, 0, 0, 0, 0, 0);
        #1 RSTn = 1'b1;
        @(negedge CLK);
        I_ARVALID = 1'b0;
        M_RVALID = 1'b0;
        #1;
        chk_ctl("ar.after", 0, 0, 1, 0, 0, 0);
        chk("ar.after.M_ARADDR", M_ARADDR, 32'h600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
